// File: rtl/hex_scroller.sv
// rtl/hex_scroller.sv - message buffer scrolled across six seven-segment digits
// Digit codes are registered one cycle behind state/len/pos; len/full/scrolling track the commanding edge.
module hex_scroller #(
  parameter int TICK_DIV = 25000000,
  parameter int MAX_LEN  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [4:0]  wr_char,
  input  logic        clr,
  input  logic        start,
  input  logic        stop,
  output logic [29:0] disp_codes,
  output logic [4:0]  len,
  output logic        full,
  output logic        scrolling
);

  localparam int            TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [4:0]    LEN_MAX   = 5'(MAX_LEN);
  localparam logic [4:0]    BLANK     = 5'd31;

  typedef enum logic {IDLE, SCROLL} state_t;

  state_t        state_q, state_d;
  logic [4:0]    len_q, len_d;
  logic [4:0]    pos_q, pos_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          full_q, full_d;
  logic          scrolling_q, scrolling_d;
  logic [29:0]   disp_q, disp_d;
  logic [4:0]    msg_q [MAX_LEN];
  logic [4:0]    msg_d [MAX_LEN];

  logic cmd_stop, cmd_start, cmd_wr;
  logic do_stop, do_start, do_wr;
  logic [5:0] seq_len, pos_inc;

  // Only the highest-priority asserted command survives decoding.
  assign cmd_stop  = !clr && stop;
  assign cmd_start = !clr && !stop && start;
  assign cmd_wr    = !clr && !stop && !start && wr_en;

  assign do_stop  = cmd_stop && (state_q == SCROLL);
  assign do_start = cmd_start && (state_q == IDLE) && (len_q != 5'd0);
  assign do_wr    = cmd_wr && (state_q == IDLE) && !full_q;

  assign seq_len = {1'b0, len_q} + 6'd6;
  assign pos_inc = {1'b0, pos_q} + 6'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr)           state_d = IDLE;
    else if (do_stop)  state_d = IDLE;
    else if (do_start) state_d = SCROLL;
  end

  always_comb begin
    len_d  = len_q;
    pos_d  = pos_q;
    tick_d = tick_q;
    if (clr) begin
      len_d  = 5'd0;
      pos_d  = 5'd0;
      tick_d = '0;
    end else if (do_stop || do_start) begin
      pos_d  = 5'd0;
      tick_d = '0;
    end else if (state_q == SCROLL) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        pos_d  = (pos_inc == seq_len) ? 5'd0 : pos_inc[4:0];
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end else begin
      tick_d = '0;
      if (do_wr) len_d = len_q + 5'd1;
    end
    full_d      = (len_d == LEN_MAX);
    scrolling_d = (state_d == SCROLL);
  end

  always_comb begin
    msg_d = msg_q;
    if (do_wr) msg_d[len_q[3:0]] = wr_char;
  end

  // Window selection: pos+k < 2L, so one conditional subtract wraps it.
  always_comb begin
    logic [5:0] idx;
    disp_d = '1;
    idx    = 6'd0;
    for (int k = 0; k < 6; k++) begin
      if (state_q == SCROLL) begin
        idx = {1'b0, pos_q} + 6'(k);
        if (idx >= seq_len) idx = idx - seq_len;
        disp_d[(5-k)*5 +: 5] = (idx < {1'b0, len_q}) ? msg_q[idx[3:0]] : BLANK;
      end else begin
        idx = {1'b0, len_q} + 6'(k);
        if (idx >= 6'd6) disp_d[(5-k)*5 +: 5] = msg_q[4'(idx - 6'd6)];
        else             disp_d[(5-k)*5 +: 5] = BLANK;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q       <= 5'd0;
      pos_q       <= 5'd0;
      tick_q      <= '0;
      full_q      <= 1'b0;
      scrolling_q <= 1'b0;
      disp_q      <= 30'h3FFFFFFF;
    end else begin
      len_q       <= len_d;
      pos_q       <= pos_d;
      tick_q      <= tick_d;
      full_q      <= full_d;
      scrolling_q <= scrolling_d;
      disp_q      <= disp_d;
    end
  end

  always_ff @(posedge clk) begin
    msg_q <= msg_d;
  end

  assign disp_codes = disp_q;
  assign len        = len_q;
  assign full       = full_q;
  assign scrolling  = scrolling_q;

endmodule

// File: tb/tb_hex_scroller.sv
// tb/tb_hex_scroller.sv - directed bench for hex_scroller with TICK_DIV=4
// Inputs change and outputs are sampled on the falling edge.
module tb_hex_scroller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_char = 5'd0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [29:0] disp_codes;
  logic [4:0]  len;
  logic        full;
  logic        scrolling;

  int tests = 0;
  int fails = 0;

  hex_scroller #(.TICK_DIV(4), .MAX_LEN(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_char(wr_char), .clr(clr),
    .start(start), .stop(stop), .disp_codes(disp_codes), .len(len),
    .full(full), .scrolling(scrolling)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] pack6(input logic [4:0] a, b, c, d, e, f);
    return {a, b, c, d, e, f};
  endfunction

  // Window of S = {0,1,31 x6}, L = 8, at position p.
  function automatic logic [29:0] win01(input int p);
    logic [29:0] w;
    int i;
    w = '0;
    for (int k = 0; k < 6; k++) begin
      i = (p + k) % 8;
      w[(5-k)*5 +: 5] = (i == 0) ? 5'd0 : (i == 1) ? 5'd1 : 5'd31;
    end
    return w;
  endfunction

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic write_char(input logic [4:0] c);
    wr_en = 1'b1; wr_char = c;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1; cycle(); clr = 1'b0;
  endtask

  task automatic test_reset();
    cycle(); cycle();
    tests++; if (len !== 5'd0) begin fails++; $display("FAIL reset_len: got %0d expected 0", len); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", full); end
    tests++; if (scrolling !== 1'b0) begin fails++; $display("FAIL reset_scrolling: got %b expected 0", scrolling); end
    tests++; if (disp_codes !== 30'h3FFFFFFF) begin fails++; $display("FAIL reset_disp: got %h expected 3fffffff", disp_codes); end
    rst = 1'b0;
  endtask

  task automatic test_idle_display();
    write_char(5'd7); write_char(5'd4); write_char(5'd11);
    tests++; if (len !== 5'd3) begin fails++; $display("FAIL idle_len: got %0d expected 3", len); end
    cycle();
    tests++; if (disp_codes !== pack6(31, 31, 31, 7, 4, 11)) begin fails++;
      $display("FAIL idle_disp: got %h expected %h", disp_codes, pack6(31, 31, 31, 7, 4, 11)); end
  endtask

  task automatic test_full();
    pulse_clr();
    for (int i = 0; i < 17; i++) write_char(5'(i));
    tests++; if (len !== 5'd16) begin fails++; $display("FAIL full_len: got %0d expected 16", len); end
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL full_flag: got %b expected 1", full); end
    cycle();
    tests++; if (disp_codes !== pack6(10, 11, 12, 13, 14, 15)) begin fails++;
      $display("FAIL full_disp: got %h expected %h", disp_codes, pack6(10, 11, 12, 13, 14, 15)); end
  endtask

  task automatic test_scroll();
    pulse_clr();
    write_char(5'd0); write_char(5'd1);
    start = 1'b1; cycle(); start = 1'b0;
    tests++; if (scrolling !== 1'b1) begin fails++; $display("FAIL scroll_start: got %b expected 1", scrolling); end
    cycle();
    tests++; if (disp_codes !== win01(0)) begin fails++;
      $display("FAIL scroll_win0: got %h expected %h", disp_codes, win01(0)); end
    for (int p = 1; p <= 8; p++) begin
      repeat (4) cycle();
      tests++; if (disp_codes !== win01(p)) begin fails++;
        $display("FAIL scroll_win%0d: got %h expected %h", p, disp_codes, win01(p)); end
    end
    wr_en = 1'b1; wr_char = 5'd9; cycle(); wr_en = 1'b0;
    tests++; if (len !== 5'd2) begin fails++; $display("FAIL scroll_wr_ignored: got %0d expected 2", len); end
    stop = 1'b1; cycle(); stop = 1'b0;
    tests++; if (scrolling !== 1'b0) begin fails++; $display("FAIL stop_scrolling: got %b expected 0", scrolling); end
    tests++; if (len !== 5'd2) begin fails++; $display("FAIL stop_len: got %0d expected 2", len); end
    cycle();
    tests++; if (disp_codes !== pack6(31, 31, 31, 31, 0, 1)) begin fails++;
      $display("FAIL stop_disp: got %h expected %h", disp_codes, pack6(31, 31, 31, 31, 0, 1)); end
  endtask

  task automatic test_priority();
    start = 1'b1; wr_en = 1'b1; wr_char = 5'd5; cycle(); start = 1'b0; wr_en = 1'b0;
    tests++; if (scrolling !== 1'b1) begin fails++; $display("FAIL prio_start_scrolling: got %b expected 1", scrolling); end
    tests++; if (len !== 5'd2) begin fails++; $display("FAIL prio_start_len: got %0d expected 2", len); end
    stop = 1'b1; start = 1'b1; cycle(); stop = 1'b0; start = 1'b0;
    tests++; if (scrolling !== 1'b0) begin fails++; $display("FAIL prio_stop_start: got %b expected 0", scrolling); end
  endtask

  task automatic test_clr();
    start = 1'b1; cycle(); start = 1'b0;
    cycle(); cycle();
    clr = 1'b1; start = 1'b1; cycle(); clr = 1'b0; start = 1'b0;
    tests++; if (len !== 5'd0) begin fails++; $display("FAIL clr_len: got %0d expected 0", len); end
    tests++; if (scrolling !== 1'b0) begin fails++; $display("FAIL clr_scrolling: got %b expected 0", scrolling); end
    cycle();
    tests++; if (disp_codes !== 30'h3FFFFFFF) begin fails++; $display("FAIL clr_disp: got %h expected 3fffffff", disp_codes); end
  endtask

  task automatic test_async_reset();
    write_char(5'd3);
    start = 1'b1; cycle(); start = 1'b0;
    repeat (3) cycle();
    #2 rst = 1'b1;
    #1;
    tests++; if (scrolling !== 1'b0) begin fails++; $display("FAIL arst_scrolling: got %b expected 0", scrolling); end
    tests++; if (len !== 5'd0) begin fails++; $display("FAIL arst_len: got %0d expected 0", len); end
    tests++; if (disp_codes !== 30'h3FFFFFFF) begin fails++; $display("FAIL arst_disp: got %h expected 3fffffff", disp_codes); end
    cycle();
    rst = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    tests++; if (scrolling !== 1'b0) begin fails++; $display("FAIL arst_start_empty: got %b expected 0", scrolling); end
    write_char(5'd2);
    tests++; if (len !== 5'd1) begin fails++; $display("FAIL arst_first_write: got %0d expected 1", len); end
  endtask

  initial begin
    test_reset();
    test_idle_display();
    test_full();
    test_scroll();
    test_priority();
    test_clr();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hex_scroller.md
HEX_SCROLLER -- requirements
Module: hex_scroller

Interface
REQ-001 Parameter TICK_DIV, default 25000000, clock cycles per scroll step (0.5 s at 50 MHz); legal range 2 or greater.
REQ-002 Parameter MAX_LEN, default 16, message buffer depth in characters; fixed at 16 for this revision.
REQ-003 Port clk  in  1  single system clock; all state changes on the rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-high.
REQ-005 Port wr_en  in  1  append wr_char to the message buffer.
REQ-006 Port wr_char  in  5  character code: 0-25 = A-Z, 26 = space, 27 = dash, 28 = digit 3, 29-31 = blank.
REQ-007 Port clr  in  1  empty the buffer and return to IDLE.
REQ-008 Port start  in  1  begin scrolling.
REQ-009 Port stop  in  1  end scrolling and return to IDLE.
REQ-010 Port disp_codes  out  30  six 5-bit codes; [29:25] = leftmost digit (HEX5), [4:0] = rightmost digit (HEX0); each field drives one seven-segment decoder.
REQ-011 Port len  out  5  number of stored characters, 0-16.
REQ-012 Port full  out  1  high when len == 16.
REQ-013 Port scrolling  out  1  high while in SCROLL.

Function
REQ-014 The FSM SHALL have two states, IDLE and SCROLL.
REQ-015 Per-cycle command priority SHALL be: clr > stop > start > wr_en; a lower-priority command asserted together with a higher one SHALL be ignored.
REQ-016 clr (any state) SHALL set len=0, pos=0, tick counter=0, and state=IDLE.
REQ-017 wr_en in IDLE with full=0 SHALL store wr_char at index len and increment len; wr_en SHALL be ignored when full=1 or in SCROLL.
REQ-018 start in IDLE with len>0 SHALL go to SCROLL with pos=0 and tick counter=0; start with len=0 or in SCROLL SHALL be ignored.
REQ-019 stop in SCROLL SHALL go to IDLE and leave buffer contents and len unchanged; stop in IDLE SHALL be a no-op.
REQ-020 Virtual sequence S, length L = len+6: S[i] = buf[i] for i < len; S[i] = 31 (blank) for len <= i < L.
REQ-021 In SCROLL, the tick counter SHALL count 0..TICK_DIV-1 and wrap; when count == TICK_DIV-1, pos SHALL advance: pos = (pos+1 == L) ? 0 : pos+1.
REQ-022 In SCROLL, digit k (k=0 leftmost .. 5) SHALL show S[(pos+k) mod L]; the modulo SHALL be a single conditional subtract of L, since pos+k < 2L.
REQ-023 In IDLE, digit k SHALL show buf[len-6+k] when len-6+k >= 0, and 31 otherwise (last entered characters right-justified).
REQ-024 The tick counter SHALL hold at 0 in IDLE.
REQ-025 disp_codes SHALL be registered and reflect the state/len/pos of the previous cycle (1-cycle latency).
REQ-026 len, full, and scrolling SHALL be registered and update in the same edge as the causing command.
REQ-027 Buffer entries at index >= len SHALL never appear on disp_codes.

Reset
REQ-028 While rst=1, the block SHALL force: state=IDLE, len=0, pos=0, tick counter=0, full=0, scrolling=0, disp_codes=30'h3FFFFFFF (all blank); buffer contents are don't-care.
REQ-029 Asserting rst during SCROLL SHALL take effect immediately, without waiting for a clock edge.
REQ-030 The first command after rst deasserts SHALL be honored at the next rising edge.

Verification (TICK_DIV=4)
REQ-031 Reset, then write 7,4,11 -> len=3; disp_codes fields (left to right) = 31,31,31,7,4,11 one cycle after the last write.
REQ-032 Write 17 characters -> len=16, full=1; the 17th write is dropped and disp_codes shows characters 10-15.
REQ-033 Buffer {0,1}, start -> scrolling=1; the first window is 0,1,31,31,31,31; pos advances every 4 cycles; after 8 steps (L=8) the window returns to 0,1,31,31,31,31.
REQ-034 Same cycle: start+wr_en in IDLE -> SCROLL entered, len unchanged; stop+start in SCROLL -> IDLE.
REQ-035 clr during SCROLL -> next edge: len=0, scrolling=0; one cycle later, disp_codes = all 31.
REQ-036 rst asserted mid-SCROLL between clock edges -> outputs go to reset values immediately; start with len=0 afterwards is ignored.
